// File: rtl/alu32_arbiter_pkg.sv
// Shared opcodes, key rules and FSM state type for the ALU arbiter.
package alu32_arbiter_pkg;

    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_MUL = 8'h03;

    // The ALU parks key_out at this value while a MUL is in progress.
    localparam logic [7:0] KEY_RESERVED = 8'h00;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CLR,
        S_DONE
    } arbState_t;

    // Next issue key: skips the reserved value on wrap.
    function automatic logic [7:0] advanceKey(input logic [7:0] key);
        return (key == 8'hFF) ? (KEY_RESERVED + 8'd1) : (key + 8'd1);
    endfunction

    function automatic logic isAluOp(input logic [7:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/alu32_arbiter_if.sv
// Requester-side bus: request vector, flattened operands, and result return.
interface alu32_arbiter_if #(
    parameter int unsigned NREQ = 4
) ();
    logic [NREQ-1:0]      req;
    logic [8*NREQ-1:0]    req_op;
    logic [32*NREQ-1:0]   req_a;
    logic [32*NREQ-1:0]   req_b;
    logic [NREQ-1:0]      done;
    logic                 err;
    logic [31:0]          rsp_data;
    logic                 busy;

    modport master (
        output req, req_op, req_a, req_b,
        input  done, err, rsp_data, busy
    );

    modport slave (
        input  req, req_op, req_a, req_b,
        output done, err, rsp_data, busy
    );
endinterface

// File: rtl/alu32_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first request after lastPtr.
module alu32_arbiter_rr_pick #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] reqVec,
    input  logic [IW-1:0]   lastPtr,
    output logic [IW-1:0]   grantIdx,
    output logic            found
);

    int unsigned idx;

    // Scan lastPtr+1 .. lastPtr+NREQ modulo NREQ, keep the first hit.
    always_comb begin
        grantIdx = '0;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = (32'(lastPtr) + i) % NREQ;
            if (!found && reqVec[IW'(idx)]) begin
                found    = 1'b1;
                grantIdx = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu32_arbiter.sv
// Round-robin sequencer sharing one alu32 among NREQ requesters, with watchdog.
module alu32_arbiter
    import alu32_arbiter_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    alu32_arbiter_if.slave     bus,
    output logic               alu_en,
    output logic               alu_clr,
    output logic [7:0]         alu_key,
    output logic [7:0]         alu_op,
    output logic [31:0]        alu_a,
    output logic [31:0]        alu_b,
    input  logic [7:0]         alu_key_out,
    input  logic [31:0]        alu_out
);

    localparam int unsigned IW = $clog2(NREQ);

    arbState_t         state, stateNext;
    logic [IW-1:0]     lastPtr, lastPtrNext;
    logic [IW-1:0]     grant, grantNext;
    logic [7:0]        cnt, cntNext;
    logic [7:0]        opNext, keyNext;
    logic [31:0]       aNext, bNext, dataNext;
    logic [NREQ-1:0]   doneNext;
    logic              errNext, clrNext, enNext, busyNext;
    logic [IW-1:0]     pickIdx;
    logic              pickFound;

    alu32_arbiter_rr_pick #(.NREQ(NREQ)) uPick (
        .reqVec   (bus.req),
        .lastPtr  (lastPtr),
        .grantIdx (pickIdx),
        .found    (pickFound)
    );

    // State and registered outputs; the op/operand outputs double as holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            lastPtr      <= IW'(NREQ - 1);
            grant        <= '0;
            cnt          <= '0;
            alu_key      <= '0;
            alu_op       <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_en       <= 1'b0;
            alu_clr      <= 1'b0;
            bus.done     <= '0;
            bus.err      <= 1'b0;
            bus.rsp_data <= '0;
            bus.busy     <= 1'b0;
        end else begin
            state        <= stateNext;
            lastPtr      <= lastPtrNext;
            grant        <= grantNext;
            cnt          <= cntNext;
            alu_key      <= keyNext;
            alu_op       <= opNext;
            alu_a        <= aNext;
            alu_b        <= bNext;
            alu_en       <= enNext;
            alu_clr      <= clrNext;
            bus.done     <= doneNext;
            bus.err      <= errNext;
            bus.rsp_data <= dataNext;
            bus.busy     <= busyNext;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        stateNext   = state;
        lastPtrNext = lastPtr;
        grantNext   = grant;
        cntNext     = cnt;
        keyNext     = alu_key;
        opNext      = alu_op;
        aNext       = alu_a;
        bNext       = alu_b;
        doneNext    = '0;
        errNext     = 1'b0;
        dataNext    = '0;
        clrNext     = 1'b0;

        case (state)
            S_IDLE: begin
                if (pickFound) begin
                    lastPtrNext = pickIdx;
                    grantNext   = pickIdx;
                    opNext      = bus.req_op[{pickIdx, 3'b000} +: 8];
                    aNext       = bus.req_a[{pickIdx, 5'b00000} +: 32];
                    bNext       = bus.req_b[{pickIdx, 5'b00000} +: 32];
                    if (isAluOp(opNext)) begin
                        keyNext   = advanceKey(alu_key);
                        cntNext   = 8'd1;
                        stateNext = S_WAIT;
                    end else begin
                        doneNext[pickIdx] = 1'b1;
                        errNext           = 1'b1;
                        stateNext         = S_DONE;
                    end
                end
            end
            S_WAIT: begin
                if (alu_key_out == alu_key) begin
                    doneNext[grant] = 1'b1;
                    dataNext        = alu_out;
                    stateNext       = S_DONE;
                end else if (cnt >= 8'(TIMEOUT)) begin
                    clrNext   = 1'b1;
                    stateNext = S_CLR;
                end else begin
                    cntNext = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
                end
            end
            S_CLR: begin
                doneNext[grant] = 1'b1;
                errNext         = 1'b1;
                stateNext       = S_DONE;
            end
            S_DONE: begin
                stateNext = S_IDLE;
            end
            default: begin
                stateNext = S_IDLE;
            end
        endcase

        enNext   = (stateNext == S_WAIT);
        busyNext = (stateNext != S_IDLE);
    end

endmodule

// File: doc/alu32_arbiter.md
# alu32_arbiter

Round-robin arbiter and sequencer that shares one `alu32` instance among `NREQ` requesters (odometry, PID and trajectory blocks). It accepts one request at a time and drives the ALU through its key handshake. It waits for the key echo, which covers single-cycle ADD/SUB and the four-pass MUL, and returns the result with a one-cycle done pulse. A watchdog clears a hung ALU and reports an error to the requester instead of stalling the bus.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 15: maximum WAIT cycles before abort, 8..255.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  NREQ  request per requester; held high with operands stable until its `done` bit pulses.
- `req_op`  in  8*NREQ  opcode, slice i = bits [8i+7:8i].
- `req_a`  in  32*NREQ  operand A, slice i = bits [32i+31:32i].
- `req_b`  in  32*NREQ  operand B, same slicing as `req_a`.
- `done`  out  NREQ  one-hot, one-cycle pulse: result for requester i is valid.
- `err`  out  1  valid with `done`; 1 means invalid opcode or timeout.
- `rsp_data`  out  32  result; valid only while a `done` bit is high.
- `busy`  out  1  high from grant until the done pulse.
- `alu_en`  out  1  to ALU `en`.
- `alu_clr`  out  1  to ALU `clr`.
- `alu_key`  out  8  to ALU `key_in`.
- `alu_op`  out  8  to ALU `op`.
- `alu_a`  out  32  to ALU `inA`.
- `alu_b`  out  32  to ALU `inB`.
- `alu_key_out`  in  8  from ALU `key_out`.
- `alu_out`  in  32  from ALU `out`.

## Operation
State machine:
- **IDLE**, with no `req` asserted: stay in IDLE.
- **IDLE**, with any `req` asserted: pick the winner by round-robin, then:
  - record the winner as the new last-grant pointer;
  - latch the winner's op, A and B into holding registers;
  - if the op is ADD (0x01), SUB (0x02) or MUL (0x03): advance `key` and go to WAIT;
  - otherwise: go to DONE with `err`=1 and data 0, without touching the ALU.
- **WAIT**, with `alu_key_out == key`: capture `alu_out` and go to DONE with `err`=0.
- **WAIT**, when the timeout counter reaches `TIMEOUT`: assert `alu_clr` for one cycle and go to DONE with `err`=1 and data 0.
- **DONE**: assert `done[grant]` for one cycle, then return to IDLE.

Arbitration:
- Search starts at last-grant + 1 and wraps modulo `NREQ`.
- The pointer resets to `NREQ-1`, so requester 0 wins first.

Key rules:
- `key` resets to 0.
- Advance: 255 → 1, otherwise +1. It never takes the value 0, because the ALU holds `key_out` at 0 while a MUL is in progress.
- Advancing guarantees `key` differs from `alu_key_out` at issue time, including right after a clear.

ALU drive:
- `alu_en` is high only in WAIT.
- `alu_op`, `alu_a` and `alu_b` come from the holding registers and stay stable through WAIT.

Requests cannot be aborted:
- If `req` drops while the request is in flight, the operation still completes and `done` still pulses.
- If `req` is still high at IDLE, it counts as a new request.

Reset (including reset mid-operation):
- State → IDLE.
- `done`, `err`, `rsp_data`, `busy`, `alu_en`, `alu_clr`, `alu_key`, `alu_op`, `alu_a`, `alu_b` → 0.
- Timeout counter → 0.
- The ALU shares `rst`, so no separate clear is needed.

## Timing
Request seen in IDLE at cycle 0:
- ADD/SUB: the ALU updates on the cycle 1 edge, WAIT sees the key match in cycle 2, `done` is high in cycle 3.
- MUL: the ALU takes 4 edges (cycles 1–4), WAIT sees the match in cycle 5, `done` is high in cycle 6.
- Invalid opcode: `done` is high in cycle 1.
- Timeout: `alu_clr` is high for one cycle `TIMEOUT` cycles after entering WAIT; `done` is high the cycle after.

Throughput:
- The arbiter returns to IDLE the cycle after `done`, so back-to-back grants are at best 4 cycles apart for ADD/SUB.
- A request held continuously by one requester cannot starve the others.

Equality and counting:
- The key-match compare uses all 8 bits.
- The timeout counter is 8 bits and saturates.

## Structure
- Opcode macros ADD/SUB/MUL and the reserved key value 0 go in `src/config.vh`, shared with `alu32`.
- Sub-module `rr_pick`: a combinational round-robin priority encoder (inputs: request vector and last pointer; outputs: grant index and a found flag), parameterized by `NREQ`.
- The top-level test wrapper instantiates the arbiter together with the real `alu32`.

## Test plan
- **Single ADD:** requester 2, 7 + 5 → `done[2]` in cycle 3, `rsp_data`=12, `err`=0.
- **MUL:** requester 0, −3 × 7 → `done[0]` in cycle 6, `rsp_data`=0xFFFFFFEB.
- **Round-robin:** all four `req` held high → grant order 0, 1, 2, 3, 0; no requester gets two grants before the others have had one.
- **Invalid opcode:** op 0x07 → `done` in cycle 1, `err`=1, `rsp_data`=0, `alu_en` never asserted.
- **Timeout:** `alu_key_out` forced stuck → `alu_clr` pulses after 15 WAIT cycles, then `done` with `err`=1; the next ADD completes normally.
- **Key wrap and reset:**
  - After 255 issued operations, the next `alu_key` is 1, never 0.
  - Asserting `rst` during a MUL WAIT → all outputs 0 the next cycle, no `done` pulse, and the next request is served normally.
